// File: rtl/vram_update_sched.sv
// VRAM port-A sequencer: full-frame CLEAR (writes with the scan) or DRAW (writes SRC_LAT clk after the scan address), no backpressure.
// Optional VRAM_SCHED_CONT_EN: redraw continuously whenever idle with nothing pending.
module vram_update_sched #(
  parameter int         H_PIX     = 640,
  parameter int         V_PIX     = 480,
  parameter int         SRC_LAT   = 2,
  parameter logic [1:0] CLR_COLOR = 2'b00
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       refresh_req,
  input  logic       clear_req,
  input  logic       mode,
  input  logic [1:0] D1,
  input  logic [1:0] D2,
  output logic [8:0] src_row,
  output logic [9:0] src_col,
  output logic       src_sel,
  output logic       wr_en,
  output logic [8:0] wr_row,
  output logic [9:0] wr_col,
  output logic [1:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_cnt
);
  localparam logic [8:0] ROW_LAST = 9'(V_PIX - 1);
  localparam logic [9:0] COL_LAST = 10'(H_PIX - 1);
  localparam logic [1:0] FL_INIT  = 2'(SRC_LAT - 1);
`ifdef VRAM_SCHED_CONT_EN
  localparam logic CONT_EN = 1'b1;
`else
  localparam logic CONT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FLUSH} state_t;

  state_t             state;
  logic [8:0]         row;
  logic [9:0]         col;
  logic               scan_on;
  logic               clr_pend;
  logic               ref_pend;
  logic               clr_wr;
  logic [8:0]         clr_row;
  logic [9:0]         clr_col;
  logic               src_vld;
  logic [1:0]         fl_cnt;
  logic [SRC_LAT-1:0]       dl_vld;
  logic [SRC_LAT-1:0][8:0]  dl_row;
  logic [SRC_LAT-1:0][9:0]  dl_col;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      scan_on   <= 1'b0;
      clr_pend  <= 1'b0;
      ref_pend  <= 1'b0;
      clr_wr    <= 1'b0;
      clr_row   <= '0;
      clr_col   <= '0;
      src_vld   <= 1'b0;
      src_row   <= '0;
      src_col   <= '0;
      src_sel   <= 1'b0;
      fl_cnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done <= 1'b0;
      // Requests during an operation merge into one pending bit each.
      if (state != IDLE) begin
        clr_pend <= clr_pend | clear_req;
        ref_pend <= ref_pend | refresh_req;
      end
      if (scan_on) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (row == ROW_LAST) begin
            row     <= '0;
            scan_on <= 1'b0;
          end else begin
            row <= row + 9'd1;
          end
        end else begin
          col <= col + 10'd1;
        end
      end
      case (state)
        IDLE: begin
          if (clear_req || clr_pend) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            clr_pend <= 1'b0;
            ref_pend <= ref_pend | refresh_req;
            row      <= '0;
            col      <= '0;
            scan_on  <= 1'b1;
          end else if (refresh_req || ref_pend || CONT_EN) begin
            state    <= DRAW;
            busy     <= 1'b1;
            ref_pend <= 1'b0;
            src_sel  <= mode;
            row      <= '0;
            col      <= '0;
            scan_on  <= 1'b1;
          end
        end
        CLEAR: begin
          clr_wr  <= scan_on;
          clr_row <= scan_on ? row : '0;
          clr_col <= scan_on ? col : '0;
          if (!scan_on) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DRAW: begin
          src_vld <= scan_on;
          src_row <= scan_on ? row : '0;
          src_col <= scan_on ? col : '0;
          if (!scan_on) begin
            state  <= FLUSH;
            fl_cnt <= FL_INIT;
          end
        end
        FLUSH: begin
          if (fl_cnt == 2'd0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            fl_cnt <= fl_cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address delay line matching the renderer pipeline, so write address lines up with D1/D2.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dl_vld <= '0;
      dl_row <= '0;
      dl_col <= '0;
    end else begin
      dl_vld[0] <= src_vld;
      dl_row[0] <= src_row;
      dl_col[0] <= src_col;
      for (int i = 1; i < SRC_LAT; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_row[i] <= dl_row[i-1];
        dl_col[i] <= dl_col[i-1];
      end
    end
  end

  assign wr_en = clr_wr | dl_vld[SRC_LAT-1];

  always_comb begin
    wr_row  = '0;
    wr_col  = '0;
    wr_data = '0;
    if (clr_wr) begin
      wr_row  = clr_row;
      wr_col  = clr_col;
      wr_data = CLR_COLOR;
    end else if (dl_vld[SRC_LAT-1]) begin
      wr_row  = dl_row[SRC_LAT-1];
      wr_col  = dl_col[SRC_LAT-1];
      wr_data = src_sel ? D2 : D1;
    end
  end

endmodule
